// File: rtl/calc1_pkg.sv
// Shared constants, FSM state type and the per-port ALU for the calc1 block.
package calc1_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int RESP_W    = 2;
  localparam int RST_W     = 7;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_RESP = 2'd2
  } port_st_e;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Error results always carry zero data; only the low 5 bits of b steer shifts.
  function automatic rsp_t alu(input logic [CMD_W-1:0] cmd,
                               input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b);
    rsp_t          r;
    logic [DATA_W:0] s;
    r.resp = RESP_ERR;
    r.data = '0;
    s      = '0;
    case (cmd)
      CMD_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        if (!s[DATA_W]) begin
          r.resp = RESP_OK;
          r.data = s[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (b <= a) begin
          r.resp = RESP_OK;
          r.data = a - b;
        end
      end
      CMD_SHL: begin
        r.resp = RESP_OK;
        r.data = a << b[4:0];
      end
      CMD_SHR: begin
        r.resp = RESP_OK;
        r.data = a >> b[4:0];
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc1_port.sv
// One calculator channel: request FSM (IDLE -> OP2 -> RESP) plus ALU and
// registered one-cycle response.
module calc1_port
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out_data,
  output logic [RESP_W-1:0] out_resp
);

  port_st_e          st, st_nx;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic              take_cmd;
  rsp_t              rsp_nx;

  // State, operand capture and registered response; reset drops any request.
  always_ff @(posedge c_clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      cmd_q    <= CMD_NOP;
      op1_q    <= '0;
      op2_q    <= '0;
      out_resp <= RESP_NONE;
      out_data <= '0;
    end else begin
      st       <= st_nx;
      out_resp <= rsp_nx.resp;
      out_data <= rsp_nx.data;
      if (take_cmd) begin
        cmd_q <= cmd_in;
        op1_q <= data_in;
      end
      if (st == ST_OP2) op2_q <= data_in;
    end
  end

  // Next state; the result is loaded into the output registers on the edge
  // leaving RESP, which is also where a new command may be accepted.
  always_comb begin
    st_nx    = st;
    rsp_nx   = '0;
    take_cmd = 1'b0;
    case (st)
      ST_IDLE: begin
        if (cmd_in != CMD_NOP) begin
          take_cmd = 1'b1;
          st_nx    = ST_OP2;
        end
      end
      ST_OP2: st_nx = ST_RESP;
      ST_RESP: begin
        rsp_nx = alu(cmd_q, op1_q, op2_q);
        if (cmd_in != CMD_NOP) begin
          take_cmd = 1'b1;
          st_nx    = ST_OP2;
        end else begin
          st_nx = ST_IDLE;
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/calc1.sv
// Four independent calculator channels sharing one clock and one reset.
module calc1
  import calc1_pkg::*;
(
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  // Ascending (bit 0 = MSB) ports map value-for-value onto descending lanes.
  logic [NUM_PORTS-1:0][CMD_W-1:0]  cmd_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] din_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] dout_v;
  logic [NUM_PORTS-1:0][RESP_W-1:0] resp_v;
  logic                             rst;

  // Any reset bit resets every channel.
  assign rst = |reset;

  assign cmd_v[0] = req1_cmd_in;
  assign cmd_v[1] = req2_cmd_in;
  assign cmd_v[2] = req3_cmd_in;
  assign cmd_v[3] = req4_cmd_in;
  assign din_v[0] = req1_data_in;
  assign din_v[1] = req2_data_in;
  assign din_v[2] = req3_data_in;
  assign din_v[3] = req4_data_in;

  assign out_data1 = dout_v[0];
  assign out_data2 = dout_v[1];
  assign out_data3 = dout_v[2];
  assign out_data4 = dout_v[3];
  assign out_resp1 = resp_v[0];
  assign out_resp2 = resp_v[1];
  assign out_resp3 = resp_v[2];
  assign out_resp4 = resp_v[3];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc1_port u_port (
      .c_clk    (c_clk),
      .rst      (rst),
      .cmd_in   (cmd_v[p]),
      .data_in  (din_v[p]),
      .out_data (dout_v[p]),
      .out_resp (resp_v[p])
    );
  end

endmodule

// File: tb/tb_calc1.sv
// Scoreboard bench for calc1: expected responses are queued per port at
// issue time and compared when their due cycle arrives; every other cycle
// the port must be silent (resp 0, data 0).
module tb_calc1;

  typedef struct {
    int          due;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        c_clk = 1'b0;
  logic [1:7]  rst_v;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [31:0] dout [4];
  logic [1:0]  resp [4];

  exp_t q [4][$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) edge_n <= edge_n + 1;

  calc1 dut (
    .c_clk        (c_clk),
    .reset        (rst_v),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (din[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (din[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (din[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (din[3]),
    .out_data1    (dout[0]),
    .out_resp1    (resp[0]),
    .out_data2    (dout[1]),
    .out_resp2    (resp[1]),
    .out_data3    (dout[2]),
    .out_resp3    (resp[2]),
    .out_data4    (dout[3]),
    .out_resp4    (resp[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Reference behaviour of one request.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] wide;
    e.due  = 0;
    e.resp = 2'd2;
    e.data = 32'h0;
    if (c == 4'd1) begin
      wide = 33'(a) + 33'(b);
      if (wide < 33'h1_0000_0000) begin e.resp = 2'd1; e.data = wide[31:0]; end
    end else if (c == 4'd2) begin
      if (a >= b) begin e.resp = 2'd1; e.data = a - b; end
    end else if (c == 4'd5) begin
      e.resp = 2'd1; e.data = a << (b % 32);
    end else if (c == 4'd6) begin
      e.resp = 2'd1; e.data = a >> (b % 32);
    end
    return e;
  endfunction

  // Monitor: compare due responses, otherwise require silence.
  always @(negedge c_clk) begin : mon
    exp_t e;
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        if (q[p].size() != 0 && q[p][0].due == edge_n) begin
          e = q[p].pop_front();
          chk($sformatf("p%0d_resp", p + 1), 32'(resp[p]), 32'(e.resp));
          chk($sformatf("p%0d_data", p + 1), dout[p], e.data);
        end else begin
          chk($sformatf("p%0d_idle_resp", p + 1), 32'(resp[p]), 32'h0);
          chk($sformatf("p%0d_idle_data", p + 1), dout[p], 32'h0);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = $urandom; end
      @(posedge c_clk); #1;
    end
  endtask

  // Two-cycle request on every port selected by en. A random nonzero cmd is
  // driven during the operand-2 cycle to exercise the busy rule; the task
  // returns in the RESP cycle so a following call is back-to-back.
  task automatic issue(input logic [3:0] en, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (en[p]) begin
        cmd[p] = c; din[p] = a;
        if (c != 4'd0) begin
          e = model(c, a, b);
          e.due = edge_n + 3;
          q[p].push_back(e);
        end
      end else begin
        cmd[p] = 4'd0; din[p] = $urandom;
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      if (en[p] && c != 4'd0) begin
        cmd[p] = 4'($urandom_range(1, 15)); din[p] = b;
      end else begin
        cmd[p] = 4'd0; din[p] = $urandom;
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = $urandom; end
  endtask

  task automatic do_reset(input int bit_idx, input int cycles);
    rst_v = '0;
    rst_v[bit_idx] = 1'b1;
    for (int p = 0; p < 4; p++) q[p].delete();
    repeat (cycles) begin @(posedge c_clk); #1; end
    rst_v = '0;
  endtask

  // Start an add on all ports, then reset after n_edges request edges.
  task automatic half_req(input int n_edges, input int bit_idx);
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd1; din[p] = 32'h1; end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = 32'h2; end
    if (n_edges > 1) begin @(posedge c_clk); #1; end
    do_reset(bit_idx, 4);
    idle(4);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [3:0]  en;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = 32'h0; end
    rst_v = '0;
    rst_v[1] = 1'b1;
    repeat (4) begin @(posedge c_clk); #1; end
    mon_en = 1'b1;
    // reset state is checked by the monitor while reset is still held
    @(posedge c_clk); #1;
    rst_v = '0;
    idle(2);

    // add on port 1
    issue(4'b0001, 4'd1, 32'h1,        32'h1FFF_FFFF);
    issue(4'b0001, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    issue(4'b0001, 4'd1, 32'h0,        32'h0);
    issue(4'b0001, 4'd1, 32'hFFFF_FFFF, 32'h1);
    issue(4'b0001, 4'd1, 32'hFFFF_FFFE, 32'h1);
    idle(3);

    // subtract and shift boundaries
    issue(4'b0010, 4'd2, 32'h1, 32'hF);
    issue(4'b0010, 4'd2, 32'h5, 32'h5);
    issue(4'b0100, 4'd5, 32'h1, 32'hFFFF_FFE3);
    issue(4'b0100, 4'd6, 32'h8000_0000, 32'h1F);
    idle(3);
    for (int k = 0; k < 30; k++) issue(4'(1 << (k % 4)), 4'd5, 32'h1 << k, 32'h1);
    for (int k = 0; k < 30; k++) issue(4'(1 << (k % 4)), 4'd6, 32'h8000_0000 >> k, 32'h1);
    idle(3);

    // invalid commands still consume the operand-2 cycle
    issue(4'b1000, 4'd3, 32'h1, 32'h1);
    idle(2);
    issue(4'b1000, 4'd4, 32'h1, 32'h1);
    issue(4'b1000, 4'd15, 32'h1, 32'h1);
    idle(3);

    // no-op with random data, then all ports concurrently
    for (int i = 0; i < 8; i++) issue(4'b1111, 4'd0, $urandom, $urandom);
    idle(2);
    issue(4'b1111, 4'd1, 32'h1, 32'h2);
    idle(3);

    // reset mid-request: in OP2, and in RESP; bit 7 alone must also work
    half_req(1, 1);
    half_req(2, 1);
    half_req(2, 7);

    // random mix
    for (int i = 0; i < 40; i++) begin
      en = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 5))
        0: c = 4'd1;
        1: c = 4'd2;
        2: c = 4'd5;
        3: c = 4'd6;
        default: c = 4'($urandom_range(0, 15));
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(en, c, a, b);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(5);

    for (int p = 0; p < 4; p++) chk($sformatf("p%0d_drained", p + 1), 32'(q[p].size()), 32'h0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
